// File: rtl/pcs_10g_tx_sched.sv
// pcs_10g_tx_sched
//   Transmit scheduler sitting between the MAC's XGMII word source and the
//   64b/66b encoder + 66:64 gearbox. It owns the gearbox sequence counter
//   and stalls the encoder input for one cycle in every SEQ_N. Between
//   frames it sends idle words. If the MAC underruns mid-frame, it sends one
//   error word and discards the rest of that frame up to its terminate word.
//
// Ports
//   clk, nreset            clock; synchronous active-low reset
//   in_valid_i/in_ready_o  MAC word handshake
//   in_txd_i/in_txc_i      MAC XGMII data/control
//   enc_v_o                encoder input valid (low on the stall cycle)
//   enc_txd_o/enc_txc_o    encoder XGMII data/control
//   gb_seq_o               gearbox sequence index, aligned with enc_*
//   frame_active_o         high while the scheduler is in DATA
//   underrun_o             one-cycle pulse aligned with the error word
//   underrun_cnt_o         saturating underrun count
//   dbg_state_o            current FSM state (IDLE=0, DATA=1, DROP=2)
//
// Handshake: a word transfers on a clk edge where in_valid_i and in_ready_o
// are both high. in_ready_o is combinational (nreset & ~pause) and does not
// depend on in_valid_i. While in_valid_i is high and in_ready_o is low, the
// MAC holds in_txd_i/in_txc_i stable.
module pcs_10g_tx_sched #(
  parameter int XGMII_DATA_W = 64,
  parameter int XGMII_CTRL_W = 8,
  parameter int SEQ_N        = 33,
  parameter int SEQ_W        = 6,
  parameter int ERR_CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [XGMII_DATA_W-1:0] in_txd_i,
  input  logic [XGMII_CTRL_W-1:0] in_txc_i,
  output logic                    enc_v_o,
  output logic [XGMII_DATA_W-1:0] enc_txd_o,
  output logic [XGMII_CTRL_W-1:0] enc_txc_o,
  output logic [SEQ_W-1:0]        gb_seq_o,
  output logic                    frame_active_o,
  output logic                    underrun_o,
  output logic [ERR_CNT_W-1:0]    underrun_cnt_o,
  output logic [1:0]              dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_DROP = 2'd2
  } state_t;

  localparam logic [XGMII_DATA_W-1:0] IDLE_TXD = {(XGMII_DATA_W/8){8'h07}};
  localparam logic [XGMII_DATA_W-1:0] ERR_TXD  = {(XGMII_DATA_W/8){8'hfe}};
  localparam logic [XGMII_CTRL_W-1:0] ALL_CTRL = '1;
  localparam logic [SEQ_W-1:0]        CNT_LAST = SEQ_W'(SEQ_N - 1);

  state_t                  r_state;
  logic [SEQ_W-1:0]        r_cnt;
  logic [SEQ_W-1:0]        r_seq;
  logic                    r_enc_v;
  logic [XGMII_DATA_W-1:0] r_txd;
  logic [XGMII_CTRL_W-1:0] r_txc;
  logic                    r_frame;
  logic                    r_underrun;
  logic [ERR_CNT_W-1:0]    r_ucnt;

  state_t                  w_state_nxt;
  logic                    w_enc_v_nxt;
  logic [XGMII_DATA_W-1:0] w_txd_nxt;
  logic [XGMII_CTRL_W-1:0] w_txc_nxt;
  logic                    w_underrun_nxt;
  logic [ERR_CNT_W-1:0]    w_ucnt_nxt;
  logic                    w_pause;
  logic                    w_xfer;
  logic                    w_start;
  logic                    w_term;

  // The gearbox swallows one 64-bit word slot per period; that slot is the
  // last count value.
  assign w_pause    = (r_cnt == CNT_LAST);
  assign in_ready_o = nreset & ~w_pause;
  assign w_xfer     = in_valid_i & in_ready_o;

  // Start may sit in lane 0 or lane 4; terminate may sit in any lane.
  assign w_start = (in_txc_i[0] && (in_txd_i[7:0]   == 8'hfb)) ||
                   (in_txc_i[4] && (in_txd_i[39:32] == 8'hfb));

  always_comb begin
    w_term = 1'b0;
    for (int i = 0; i < XGMII_CTRL_W; i++) begin
      if (in_txc_i[i] && (in_txd_i[8*i +: 8] == 8'hfd)) w_term = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_enc_v_nxt    = 1'b0;
    w_txd_nxt      = r_txd;
    w_txc_nxt      = r_txc;
    w_underrun_nxt = 1'b0;
    w_ucnt_nxt     = r_ucnt;
    // On the stall cycle everything holds and the encoder sees valid low.
    if (!w_pause) begin
      w_enc_v_nxt = 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            w_txd_nxt = in_txd_i;
            w_txc_nxt = in_txc_i;
            if (w_term)       w_state_nxt = S_IDLE;
            else if (w_start) w_state_nxt = S_DATA;
          end else begin
            w_txd_nxt = IDLE_TXD;
            w_txc_nxt = ALL_CTRL;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            w_txd_nxt = in_txd_i;
            w_txc_nxt = in_txc_i;
            if (w_term) w_state_nxt = S_IDLE;
          end else begin
            w_txd_nxt      = ERR_TXD;
            w_txc_nxt      = ALL_CTRL;
            w_underrun_nxt = 1'b1;
            if (r_ucnt != '1) w_ucnt_nxt = r_ucnt + ERR_CNT_W'(1);
            w_state_nxt    = S_DROP;
          end
        end
        S_DROP: begin
          w_txd_nxt = IDLE_TXD;
          w_txc_nxt = ALL_CTRL;
          if (w_xfer && w_term) w_state_nxt = S_IDLE;
        end
        default: begin
          w_txd_nxt   = IDLE_TXD;
          w_txc_nxt   = ALL_CTRL;
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_seq      <= '0;
      r_enc_v    <= 1'b0;
      r_txd      <= IDLE_TXD;
      r_txc      <= ALL_CTRL;
      r_frame    <= 1'b0;
      r_underrun <= 1'b0;
      r_ucnt     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_pause ? '0 : r_cnt + SEQ_W'(1);
      r_seq      <= r_cnt;
      r_enc_v    <= w_enc_v_nxt;
      r_txd      <= w_txd_nxt;
      r_txc      <= w_txc_nxt;
      r_frame    <= (w_state_nxt == S_DATA);
      r_underrun <= w_underrun_nxt;
      r_ucnt     <= w_ucnt_nxt;
    end
  end

  assign enc_v_o        = r_enc_v;
  assign enc_txd_o      = r_txd;
  assign enc_txc_o      = r_txc;
  assign gb_seq_o       = r_seq;
  assign frame_active_o = r_frame;
  assign underrun_o     = r_underrun;
  assign underrun_cnt_o = r_ucnt;
  assign dbg_state_o    = r_state;

endmodule
